// File: rtl/regfile_dump.sv
// regfile_dump: walks register-file addresses FIRST_REG..LAST_REG through one
// read port and streams each word as big-endian bytes over a valid/ready
// byte interface. The block only reads the register file.
//
// Optional feature: define REGDUMP_HEADER_EN to prefix every register with a
// header byte {3'b000, reg_idx}, giving 5 bytes per register.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start_i          dump request, honoured only in IDLE
//   Read_Register_o  address to the register-file read port
//   Read_Data_i      combinational read data for Read_Register_o
//   byte_o           outgoing byte
//   byte_valid_o     byte_o is valid
//   byte_ready_i     sink accepts byte_o this cycle
//   busy_o           dump in progress (any state except IDLE)
//   done_o           one-cycle pulse after the final byte is accepted
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned width32   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic [4:0]         Read_Register_o,
    input  logic [width32-1:0] Read_Data_i,
    output logic [7:0]         byte_o,
    output logic               byte_valid_o,
    input  logic               byte_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 3;
`ifdef REGDUMP_HEADER_EN
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(4);
`else
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(3);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   reg_idx;
    logic [width32-1:0] shift;
    logic [CNT_W-1:0]   cnt;
    logic               last_byte;
    logic               last_reg;
    logic               xfer;

    assign last_byte = (cnt == LAST_BYTE);
    assign last_reg  = (reg_idx == IDX_W'(LAST_REG));
    // byte_valid_o is exactly "state is SEND", so this is the handshake.
    assign xfer      = (state == SEND) && byte_ready_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = ADDR;
            ADDR: state_nxt = SEND;
            SEND: begin
                if (xfer && last_byte) begin
                    state_nxt = last_reg ? DONE : ADDR;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: register index, captured word and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_idx <= IDX_W'(FIRST_REG);
            shift   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) reg_idx <= IDX_W'(FIRST_REG);
                end
                ADDR: begin
                    // Snapshot: later register-file writes do not affect this word.
                    shift <= Read_Data_i;
                    cnt   <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        cnt <= cnt + CNT_W'(1);
`ifdef REGDUMP_HEADER_EN
                        // Count 0 is the header byte; data shifts only after it.
                        if (cnt != '0) shift <= shift << 8;
`else
                        shift <= shift << 8;
`endif
                        if (last_byte && !last_reg) reg_idx <= reg_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from registered state and datapath only.
    always_comb begin
        Read_Register_o = IDX_W'(FIRST_REG);
        byte_o          = 8'h00;
        byte_valid_o    = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        case (state)
            IDLE: busy_o = 1'b0;
            ADDR: Read_Register_o = reg_idx;
            SEND: begin
                Read_Register_o = reg_idx;
                byte_valid_o    = 1'b1;
`ifdef REGDUMP_HEADER_EN
                byte_o = (cnt == '0) ? {3'b000, reg_idx} : shift[width32-1 -: 8];
`else
                byte_o = shift[width32-1 -: 8];
`endif
            end
            DONE: begin
                Read_Register_o = reg_idx;
                done_o          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: register-file model, scoreboard of expected
// bytes pushed at start, negedge monitor popping on each accepted byte.
module tb_regfile_dump;

`ifdef REGDUMP_HEADER_EN
    localparam int unsigned FIRST = 30;
    localparam int unsigned LAST  = 31;
    localparam int unsigned NB    = 5;
`else
    localparam int unsigned FIRST = 0;
    localparam int unsigned LAST  = 31;
    localparam int unsigned NB    = 4;
`endif
    localparam int unsigned NREG     = LAST - FIRST + 1;
    localparam int unsigned SNAP_REG = (FIRST <= 3) ? 3 : FIRST;
    localparam int unsigned RST_REG  = (FIRST <= 7) ? 7 : FIRST;
    localparam int unsigned BP_REG   = (FIRST <= 5) ? 5 : FIRST;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  bytev;
    logic        valid;
    logic        busy;
    logic        done;
    logic [31:0] rf [32];

    assign rd_data = rf[rd_addr];

    always #5 clk = ~clk;

    regfile_dump #(
        .FIRST_REG(FIRST),
        .LAST_REG (LAST),
        .width32  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .Read_Register_o(rd_addr),
        .Read_Data_i    (rd_data),
        .byte_o         (bytev),
        .byte_valid_o   (valid),
        .byte_ready_i   (ready),
        .busy_o         (busy),
        .done_o         (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] sb[$];
    int  cyc = 0;
    int  start_ng = 0;
    int  done_cnt = 0;
    int  rx_cnt = 0;
    bit  lat_chk = 1'b0;
    bit  stall_prev = 1'b0;
    bit  busy_prev = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    // Monitor: at negedge, valid&&ready means the next posedge transfers.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
            busy_prev  = 1'b0;
        end else begin
            if (busy && !busy_prev) start_ng = cyc;
            busy_prev = busy;
            if (stall_prev) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_byte", 32'(bytev), 32'(stall_byte));
            end
            stall_prev = valid && !ready;
            stall_byte = bytev;
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    check("sb_extra_byte", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("byte", 32'(bytev), 32'(e));
                    rx_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                check("sb_left_at_done", 32'(sb.size()), 32'd0);
                if (lat_chk) check("latency", 32'(cyc - start_ng), 32'(NREG * (NB + 1)));
            end
        end
    end

    task automatic push_dump();
        for (int r = FIRST; r <= LAST; r++) begin
`ifdef REGDUMP_HEADER_EN
            sb.push_back(8'(r));
`endif
            for (int b = 3; b >= 0; b--) sb.push_back(rf[r][8*b +: 8]);
        end
    endtask

    task automatic run_start();
        @(posedge clk);
        #1;
        push_dump();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (20) @(posedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    bit bp_stop = 1'b0;

    initial begin
        int rx0;
        int n;
        int d0;
        bit hit;

        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | 32'(i);

        // Reset and idle.
        repeat (3) @(posedge clk);
        #2;
        check("in_reset", 32'({busy, valid, done, rd_addr, bytev}), 32'({3'b000, 5'(FIRST), 8'h00}));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", 32'({busy, valid, done, rd_addr, bytev}), 32'({3'b000, 5'(FIRST), 8'h00}));
        end

        // Full dump with ready held high; latency checked at done.
        ready   = 1'b1;
        lat_chk = 1'b1;
        rx0     = rx_cnt;
        run_start();
        wait_done(600);
        lat_chk = 1'b0;
        check("full_dump_bytes", 32'(rx_cnt - rx0), 32'(NREG * NB));

        // Backpressure with a distinctive word.
        rf[BP_REG] = 32'hDEAD_BEEF;
        rx0 = rx_cnt;
        bp_stop = 1'b0;
        fork
            begin
                while (!bp_stop) begin
                    @(posedge clk);
                    #1 ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                run_start();
                wait_done(3000);
                bp_stop = 1'b1;
            end
        join
        ready = 1'b1;
        check("bp_bytes", 32'(rx_cnt - rx0), 32'(NREG * NB));

        // Snapshot: overwrite during SEND of SNAP_REG and pulse start mid-dump.
        run_start();
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 1000) begin
            @(negedge clk);
            n++;
            if (valid && rd_addr == 5'(SNAP_REG)) hit = 1'b1;
        end
        check("snap_reach", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        rf[SNAP_REG] = 32'h1111_1111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(600);

        // Reset mid-dump after 2 bytes of RST_REG, then restart.
        for (int i = 0; i < 32; i++) rf[i] = 32'h5A00_0000 | (32'(i) << 8) | 32'(i);
        rx0 = rx_cnt;
        run_start();
        n = 0;
        while (rx_cnt < rx0 + int'((RST_REG - FIRST) * NB) + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", 32'(rx_cnt - rx0), 32'((RST_REG - FIRST) * NB + 2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({busy, valid, done, rd_addr, bytev}), 32'({3'b000, 5'(FIRST), 8'h00}));
        sb.delete();
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
        rx0 = rx_cnt;
        run_start();
        wait_done(600);
        check("restart_bytes", 32'(rx_cnt - rx0), 32'(NREG * NB));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
